// File: rtl/ddr_arbiter_if.sv
// Requester-side and DDRAM-side signal bundle for ddr_arbiter.
// slave = arbiter view, master = requester/DDR environment view.
interface ddr_arbiter_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
);
  localparam int MW = DATA_WIDTH / 8;

  logic [2:0]               in_rd;
  logic [2:0]               in_wr;
  logic [3*ADDR_WIDTH-1:0]  in_addr;
  logic [3*BURST_WIDTH-1:0] in_burstLength;
  logic [3*MW-1:0]          in_mask;
  logic [3*DATA_WIDTH-1:0]  in_din;
  logic [2:0]               in_waitReq;
  logic [2:0]               in_valid;
  logic [2:0]               in_burstDone;
  logic [DATA_WIDTH-1:0]    in_dout;

  logic                     ddr_rd;
  logic                     ddr_wr;
  logic [ADDR_WIDTH-1:0]    ddr_addr;
  logic [BURST_WIDTH-1:0]   ddr_burstLength;
  logic [MW-1:0]            ddr_mask;
  logic [DATA_WIDTH-1:0]    ddr_din;
  logic [DATA_WIDTH-1:0]    ddr_dout;
  logic                     ddr_waitReq;
  logic                     ddr_valid;

  modport slave (
    input  in_rd, in_wr, in_addr, in_burstLength, in_mask, in_din,
    output in_waitReq, in_valid, in_burstDone, in_dout,
    output ddr_rd, ddr_wr, ddr_addr, ddr_burstLength, ddr_mask, ddr_din,
    input  ddr_dout, ddr_waitReq, ddr_valid
  );

  modport master (
    output in_rd, in_wr, in_addr, in_burstLength, in_mask, in_din,
    input  in_waitReq, in_valid, in_burstDone, in_dout,
    input  ddr_rd, ddr_wr, ddr_addr, ddr_burstLength, ddr_mask, ddr_din,
    output ddr_dout, ddr_waitReq, ddr_valid
  );
endinterface

// File: rtl/ddr_arbiter.sv
// Three-port burst arbiter in front of the DDRAM Avalon port (clk_sys).
// DDR_ARBITER_ROUND_ROBIN_EN selects round-robin; default is fixed priority 0>1>2.
module ddr_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
) (
  input logic          clock,
  input logic          reset,
  ddr_arbiter_if.slave bus
);
  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE, READ_CMD, READ_DATA, WRITE
  } state_t;

  state_t state, state_nxt;
  logic [1:0] grant, grant_nxt;
  logic [BURST_WIDTH:0] len, len_nxt;
  logic [BURST_WIDTH:0] cnt, cnt_nxt;

  logic [3:0] rd4, wr4, req4;
  logic [ADDR_WIDTH-1:0]  addr_a [4];
  logic [BURST_WIDTH-1:0] blen_a [4];
  logic [MW-1:0]          mask_a [4];
  logic [DATA_WIDTH-1:0]  din_a  [4];

  assign rd4  = {1'b0, bus.in_rd};
  assign wr4  = {1'b0, bus.in_wr};
  assign req4 = rd4 | wr4;

  for (genvar i = 0; i < 3; i++) begin : g_slice
    assign addr_a[i] = bus.in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign blen_a[i] = bus.in_burstLength[i*BURST_WIDTH +: BURST_WIDTH];
    assign mask_a[i] = bus.in_mask[i*MW +: MW];
    assign din_a[i]  = bus.in_din[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign addr_a[3] = '0;
  assign blen_a[3] = '0;
  assign mask_a[3] = '0;
  assign din_a[3]  = '0;

  logic [1:0] win;
  logic       win_ok;

`ifdef DDR_ARBITER_ROUND_ROBIN_EN
  logic [1:0] ptr;

  function automatic logic [1:0] wrap_add(logic [1:0] p, int k);
    logic [2:0] s;
    s = {1'b0, p} + 3'(k);
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!win_ok && req4[wrap_add(ptr, k)]) begin
        win    = wrap_add(ptr, k);
        win_ok = 1'b1;
      end
    end
  end

  // ptr holds the port searched first on the next arbitration
  always_ff @(posedge clock) begin
    if (reset) ptr <= '0;
    else if (state == IDLE && win_ok)
      ptr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
  end
`else
  always_comb begin
    win    = '0;
    win_ok = |req4;
    if (req4[0])      win = 2'd0;
    else if (req4[1]) win = 2'd1;
    else if (req4[2]) win = 2'd2;
  end
`endif

  logic [3:0] wait_q, valid_q, done_q;
  logic       rd_o, wr_o, last;

  assign last = (cnt == len - 1'b1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      len   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      len   <= len_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    len_nxt   = len;
    cnt_nxt   = cnt;
    wait_q    = 4'hF;
    valid_q   = 4'h0;
    done_q    = 4'h0;
    rd_o      = 1'b0;
    wr_o      = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_ok) begin
          grant_nxt = win;
          len_nxt   = (blen_a[win] == '0) ? (BURST_WIDTH+1)'(1)
                                          : {1'b0, blen_a[win]};
          cnt_nxt   = '0;
          state_nxt = rd4[win] ? READ_CMD : WRITE;
        end
      end
      READ_CMD: begin
        rd_o          = rd4[grant];
        wait_q[grant] = bus.ddr_waitReq;
        if (rd_o && !bus.ddr_waitReq) begin
          cnt_nxt   = '0;
          state_nxt = READ_DATA;
        end
      end
      READ_DATA: begin
        valid_q[grant] = bus.ddr_valid;
        if (bus.ddr_valid) begin
          cnt_nxt = cnt + 1'b1;
          if (last) begin
            done_q[grant] = 1'b1;
            state_nxt     = IDLE;
          end
        end
      end
      WRITE: begin
        wr_o          = wr4[grant];
        wait_q[grant] = bus.ddr_waitReq;
        if (wr_o && !bus.ddr_waitReq) begin
          cnt_nxt = cnt + 1'b1;
          if (last) begin
            done_q[grant] = 1'b1;
            state_nxt     = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_waitReq      = wait_q[2:0];
  assign bus.in_valid        = valid_q[2:0];
  assign bus.in_burstDone    = done_q[2:0];
  assign bus.in_dout         = bus.ddr_dout;
  assign bus.ddr_rd          = rd_o;
  assign bus.ddr_wr          = wr_o;
  assign bus.ddr_addr        = addr_a[grant];
  assign bus.ddr_burstLength = blen_a[grant];
  assign bus.ddr_mask        = mask_a[grant];
  assign bus.ddr_din         = din_a[grant];
endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter: reads, stalled writes, arbitration,
// rd+wr precedence, mid-burst reset and zero burst length.
module tb_ddr_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ddr_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .BURST_WIDTH(8)) bus ();

  ddr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .BURST_WIDTH(8)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  // IDLE -> WRITE (one beat, no stall) -> IDLE; reports the granted port
  task automatic one_grant(input string tag, output int g);
    tick();
    g = -1;
    for (int i = 0; i < 3; i++)
      if (!bus.in_waitReq[i]) g = i;
    check({tag, "_wr"}, 64'(bus.ddr_wr), 64'd1);
    tick();
    settle();
  endtask

  logic [63:0] dat [4];
  int acc;
  int g;
  int exp_cont [4];
  int exp_drop [3];

  initial begin
    dat[0] = 64'h1111_2222_3333_4444;
    dat[1] = 64'h5555_6666_7777_8888;
    dat[2] = 64'h9999_AAAA_BBBB_CCCC;
    dat[3] = 64'hDDDD_EEEE_FFFF_0000;
`ifdef DDR_ARBITER_ROUND_ROBIN_EN
    exp_cont = '{0, 1, 2, 0};
    exp_drop = '{1, 2, 0};
`else
    exp_cont = '{0, 0, 0, 0};
    exp_drop = '{0, 1, 2};
`endif
    bus.in_rd = '0;
    bus.in_wr = '0;
    bus.in_addr = '0;
    bus.in_burstLength = '0;
    bus.in_mask = '0;
    bus.in_din = '0;
    bus.ddr_dout = 64'hDEAD_BEEF_0000_0001;
    bus.ddr_waitReq = 1'b0;
    bus.ddr_valid = 1'b1;
    do_reset();

    check("rst_wait", 64'(bus.in_waitReq), 64'h7);
    check("rst_valid", 64'(bus.in_valid), 64'h0);
    check("rst_done", 64'(bus.in_burstDone), 64'h0);
    check("rst_rd", 64'(bus.ddr_rd), 64'h0);
    check("rst_wr", 64'(bus.ddr_wr), 64'h0);
    bus.ddr_valid = 1'b0;

    // port 2 read, burst 4
    bus.in_rd[2] = 1'b1;
    bus.in_addr[64 +: 32] = 32'h3000_0000;
    bus.in_burstLength[16 +: 8] = 8'd4;
    settle();
    check("rd_idle_rd", 64'(bus.ddr_rd), 64'h0);
    tick();
    check("rd_cmd_rd", 64'(bus.ddr_rd), 64'h1);
    check("rd_cmd_addr", 64'(bus.ddr_addr), 64'h3000_0000);
    check("rd_cmd_len", 64'(bus.ddr_burstLength), 64'd4);
    check("rd_cmd_wait", 64'(bus.in_waitReq), 64'h3);
    tick();
    bus.in_rd[2] = 1'b0;
    check("rd_data_rd", 64'(bus.ddr_rd), 64'h0);
    for (int i = 0; i < 4; i++) begin
      bus.ddr_valid = 1'b1;
      bus.ddr_dout = dat[i];
      settle();
      check($sformatf("rd_v%0d", i), 64'(bus.in_valid), 64'h4);
      check($sformatf("rd_d%0d", i), bus.in_dout, dat[i]);
      check($sformatf("rd_done%0d", i), 64'(bus.in_burstDone),
            (i == 3) ? 64'h4 : 64'h0);
      tick();
    end
    bus.ddr_valid = 1'b1;
    settle();
    check("rd_back_idle_wait", 64'(bus.in_waitReq), 64'h7);
    check("rd_back_idle_valid", 64'(bus.in_valid), 64'h0);
    bus.ddr_valid = 1'b0;

    // port 1 write, burst 2, DDR stalls 3 cycles
    bus.in_wr[1] = 1'b1;
    bus.in_addr[32 +: 32] = 32'h0010_0000;
    bus.in_burstLength[8 +: 8] = 8'd2;
    bus.in_mask[8 +: 8] = 8'hFF;
    bus.in_din[64 +: 64] = dat[0];
    bus.ddr_waitReq = 1'b1;
    acc = 0;
    tick();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("wr_stall_wr%0d", c), 64'(bus.ddr_wr), 64'h1);
      check($sformatf("wr_stall_wait%0d", c), 64'(bus.in_waitReq), 64'h7);
      check($sformatf("wr_stall_done%0d", c), 64'(bus.in_burstDone), 64'h0);
      if (bus.ddr_wr && !bus.ddr_waitReq) acc++;
      tick();
    end
    bus.ddr_waitReq = 1'b0;
    settle();
    check("wr_b0_wait", 64'(bus.in_waitReq), 64'h5);
    check("wr_b0_addr", 64'(bus.ddr_addr), 64'h0010_0000);
    check("wr_b0_din", bus.ddr_din, dat[0]);
    check("wr_b0_done", 64'(bus.in_burstDone), 64'h0);
    if (bus.ddr_wr && !bus.ddr_waitReq) acc++;
    tick();
    bus.in_din[64 +: 64] = dat[1];
    settle();
    check("wr_b1_din", bus.ddr_din, dat[1]);
    check("wr_b1_done", 64'(bus.in_burstDone), 64'h2);
    if (bus.ddr_wr && !bus.ddr_waitReq) acc++;
    tick();
    bus.in_wr[1] = 1'b0;
    settle();
    check("wr_beats", 64'(acc), 64'd2);
    check("wr_idle_wr", 64'(bus.ddr_wr), 64'h0);
    check("wr_idle_wait", 64'(bus.in_waitReq), 64'h7);

    // arbitration among three single-beat writers
    do_reset();
    bus.in_burstLength = {8'd1, 8'd1, 8'd1};
    bus.in_wr = 3'b111;
    settle();
    for (int k = 0; k < 4; k++) begin
      one_grant($sformatf("cont%0d", k), g);
      check($sformatf("cont_grant%0d", k), 64'(g), 64'(exp_cont[k]));
    end
    for (int k = 0; k < 3; k++) begin
      one_grant($sformatf("drop%0d", k), g);
      check($sformatf("drop_grant%0d", k), 64'(g), 64'(exp_drop[k]));
      if (g >= 0) bus.in_wr[g] = 1'b0;
      settle();
    end
    bus.in_wr = '0;
    settle();

    // port 0 asserts rd and wr together: read first
    bus.in_rd[0] = 1'b1;
    bus.in_wr[0] = 1'b1;
    bus.in_burstLength[0 +: 8] = 8'd1;
    tick();
    check("rw_cmd_rd", 64'(bus.ddr_rd), 64'h1);
    check("rw_cmd_wr", 64'(bus.ddr_wr), 64'h0);
    tick();
    bus.in_rd[0] = 1'b0;
    bus.ddr_valid = 1'b1;
    bus.ddr_dout = dat[2];
    settle();
    check("rw_rd_valid", 64'(bus.in_valid), 64'h1);
    check("rw_rd_done", 64'(bus.in_burstDone), 64'h1);
    tick();
    bus.ddr_valid = 1'b0;
    settle();
    check("rw_idle_wait", 64'(bus.in_waitReq), 64'h7);
    tick();
    check("rw_wr_wr", 64'(bus.ddr_wr), 64'h1);
    check("rw_wr_rd", 64'(bus.ddr_rd), 64'h0);
    check("rw_wr_done", 64'(bus.in_burstDone), 64'h1);
    tick();
    bus.in_wr[0] = 1'b0;
    settle();

    // reset during READ_DATA after one of four beats
    bus.in_rd[2] = 1'b1;
    bus.in_burstLength[16 +: 8] = 8'd4;
    tick();
    tick();
    bus.in_rd[2] = 1'b0;
    bus.ddr_valid = 1'b1;
    bus.ddr_dout = dat[0];
    settle();
    check("mid_v0", 64'(bus.in_valid), 64'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i < 4; i++) begin
      bus.ddr_dout = dat[i];
      settle();
      check($sformatf("stray_valid%0d", i), 64'(bus.in_valid), 64'h0);
      check($sformatf("stray_wait%0d", i), 64'(bus.in_waitReq), 64'h7);
      check($sformatf("stray_done%0d", i), 64'(bus.in_burstDone), 64'h0);
      tick();
    end
    bus.ddr_valid = 1'b0;
    bus.in_rd[1] = 1'b1;
    bus.in_addr[32 +: 32] = 32'h0020_0040;
    bus.in_burstLength[8 +: 8] = 8'd1;
    tick();
    check("post_cmd_rd", 64'(bus.ddr_rd), 64'h1);
    check("post_cmd_addr", 64'(bus.ddr_addr), 64'h0020_0040);
    check("post_cmd_wait", 64'(bus.in_waitReq), 64'h5);
    tick();
    bus.in_rd[1] = 1'b0;
    bus.ddr_valid = 1'b1;
    bus.ddr_dout = dat[3];
    settle();
    check("post_valid", 64'(bus.in_valid), 64'h2);
    check("post_done", 64'(bus.in_burstDone), 64'h2);
    check("post_dout", bus.in_dout, dat[3]);
    tick();
    bus.ddr_valid = 1'b0;

    // zero burst length acts as one beat
    bus.in_wr[2] = 1'b1;
    bus.in_burstLength[16 +: 8] = 8'd0;
    tick();
    check("z_wr", 64'(bus.ddr_wr), 64'h1);
    check("z_done", 64'(bus.in_burstDone), 64'h4);
    tick();
    bus.in_wr[2] = 1'b0;
    settle();
    check("z_idle_wr", 64'(bus.ddr_wr), 64'h0);
    check("z_idle_wait", 64'(bus.in_waitReq), 64'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
